arbiter_pop_stage: RTL and testbench

Downstream stage of the weighted round-robin arbiter. Takes the arbiter's `selector`/`selector_enb` decision, pops exactly one word from the selected input FIFO, and tags the word with its source queue. The tagged word goes into a 2-entry output buffer with a valid/ready handshake toward the next stage. The block also returns a per-cycle advance strobe to the arbiter so that its weight counters only move when a word is actually consumed.

---
 rtl/arbiter_pop_stage.sv | 119 +++++++++++
 tb/tb_arbiter_pop_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/arbiter_pop_stage.sv
// arbiter_pop_stage: pops one word per cycle from the FIFO picked by the
// weighted round-robin arbiter, tags it with its source queue and holds it
// in a 2-entry valid/ready output buffer. arb_advance tells the arbiter a
// word was really consumed, so its weight counters only move on real pops.
module arbiter_pop_stage #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int BUF_WIDTH      = 3,
  parameter int CNT_BITS       = 16,
  localparam int SEL_BITS      = $clog2(QUEUE_QUANTITY)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enb,
  input  logic [SEL_BITS-1:0]               selector,
  input  logic                              selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]         buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  output logic [QUEUE_QUANTITY-1:0]         pop,
  output logic                              arb_advance,
  output logic [DATA_BITS-1:0]              data_out,
  output logic [SEL_BITS-1:0]               src_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic [CNT_BITS-1:0]               total_pops,
  output logic                              underflow_err
);

  logic [DATA_BITS-1:0] r_mem_data [2];
  logic [SEL_BITS-1:0]  r_mem_src  [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_occ;
  logic [CNT_BITS-1:0]  r_total;
  logic                 r_underflow;

  logic                 w_sel_empty;
  logic                 w_req;
  logic                 w_take;
  logic                 w_drain;
  logic [DATA_BITS-1:0] w_word;
  logic [QUEUE_QUANTITY-1:0] w_pop;
  logic                 w_unused_cfg;

  // FIFO counter width only matters to the FIFO bank, not to this stage.
  assign w_unused_cfg = (BUF_WIDTH > 0);

  assign w_sel_empty = buf_empty[selector];
  assign w_req       = enb & selector_enb;
  // Full buffer blocks the pop even if a drain happens this cycle, so
  // ready_in never reaches pop combinationally. Reset forces pop low.
  assign w_take      = rst & w_req & ~w_sel_empty & (r_occ != 2'd2);
  assign w_drain     = valid_out & ready_in;

  // Select the show-ahead head word of the chosen queue.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (selector == SEL_BITS'(i)) w_word = fifo_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // One-hot read strobe toward the FIFO bank.
  always_comb begin
    w_pop = '0;
    if (w_take) w_pop[selector] = 1'b1;
  end

  assign pop         = w_pop;
  assign arb_advance = w_take;

  // Output buffer storage and write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_data[0] <= '0;
      r_mem_data[1] <= '0;
      r_mem_src[0]  <= '0;
      r_mem_src[1]  <= '0;
      r_wptr        <= 1'b0;
    end else if (w_take) begin
      r_mem_data[r_wptr] <= w_word;
      r_mem_src[r_wptr]  <= selector;
      r_wptr             <= ~r_wptr;
    end
  end

  // Read pointer and occupancy; simultaneous push and drain cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_drain) r_rptr <= ~r_rptr;
      case ({w_take, w_drain})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Free-running pop counter (wraps) and sticky empty-queue selection flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_total     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_take) r_total <= r_total + CNT_BITS'(1);
      if (w_req & w_sel_empty) r_underflow <= 1'b1;
    end
  end

  assign valid_out     = (r_occ != 2'd0);
  assign data_out      = valid_out ? r_mem_data[r_rptr] : '0;
  assign src_out       = valid_out ? r_mem_src[r_rptr] : '0;
  assign total_pops    = r_total;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_arbiter_pop_stage.sv
module tb_arbiter_pop_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enb = 1'b0;
  logic        selector_enb = 1'b0;
  logic        ready_in = 1'b0;
  logic [1:0]  selector = 2'd0;
  logic [3:0]  buf_empty = 4'hF;
  logic [31:0] fifo_data = '0;

  logic [3:0]  pop, pop_w;
  logic        arb_advance, arb_advance_w;
  logic [7:0]  data_out, data_out_w;
  logic [1:0]  src_out, src_out_w;
  logic        valid_out, valid_out_w;
  logic [15:0] total_pops;
  logic [4:0]  total_pops_w;
  logic        underflow_err, underflow_err_w;

  arbiter_pop_stage #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .BUF_WIDTH(3), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .enb(enb), .selector(selector), .selector_enb(selector_enb),
    .buf_empty(buf_empty), .fifo_data(fifo_data), .pop(pop), .arb_advance(arb_advance),
    .data_out(data_out), .src_out(src_out), .valid_out(valid_out), .ready_in(ready_in),
    .total_pops(total_pops), .underflow_err(underflow_err));

  // Narrow-counter instance so the counter wrap is reached in a short run.
  arbiter_pop_stage #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .BUF_WIDTH(3), .CNT_BITS(5)) dut_w (
    .clk(clk), .rst(rst), .enb(enb), .selector(selector), .selector_enb(selector_enb),
    .buf_empty(buf_empty), .fifo_data(fifo_data), .pop(pop_w), .arb_advance(arb_advance_w),
    .data_out(data_out_w), .src_out(src_out_w), .valid_out(valid_out_w), .ready_in(ready_in),
    .total_pops(total_pops_w), .underflow_err(underflow_err_w));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] src;
    logic [7:0] data;
  } word_t;

  // Reference model: FIFO contents, buffered words in order, counters.
  logic [7:0] fmem [4][256];
  int         frd [4];
  int         fwr [4];
  word_t      oq [$];
  int         pops;
  bit         uf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int q, input logic [7:0] d);
    fmem[q][fwr[q] % 256] = d;
    fwr[q]++;
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < 4; i++) begin
      buf_empty[i] = (frd[i] == fwr[i]);
      fifo_data[i*8 +: 8] = buf_empty[i] ? 8'($urandom) : fmem[i][frd[i] % 256];
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, valid_out, (oq.size() != 0));
    chk({tag, ".data"}, data_out, (oq.size() != 0) ? oq[0].data : 8'h00);
    chk({tag, ".src"}, src_out, (oq.size() != 0) ? oq[0].src : 2'd0);
    chk({tag, ".total"}, total_pops, pops % 65536);
    chk({tag, ".total_w"}, total_pops_w, pops % 32);
    chk({tag, ".uf"}, underflow_err, uf);
  endtask

  // One clock cycle: drive at negedge, check combinational strobes, then
  // advance the model at the edge and check registered outputs.
  task automatic step(input string tag, input bit e, input bit se, input logic [1:0] s, input bit r);
    bit exp_take;
    bit drain;
    logic [3:0] exp_pop;
    enb = e; selector_enb = se; selector = s; ready_in = r;
    drive_fifo();
    #1;
    exp_take = e && se && (frd[s] != fwr[s]) && (oq.size() < 2);
    exp_pop  = exp_take ? (4'b0001 << s) : 4'b0000;
    drain    = (oq.size() != 0) && r;
    chk({tag, ".pop"}, pop, exp_pop);
    chk({tag, ".adv"}, arb_advance, exp_take);
    chk({tag, ".pop_w"}, pop_w, exp_pop);
    if (e && se && (frd[s] == fwr[s])) uf = 1'b1;
    @(posedge clk);
    if (drain) void'(oq.pop_front());
    if (exp_take) begin
      oq.push_back('{src: s, data: fmem[s][frd[s] % 256]});
      frd[s]++;
      pops++;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin frd[i] = 0; fwr[i] = 0; end
    pops = 0; uf = 1'b0;
    drive_fifo();
    #1;
    check_outputs("reset");
    chk("reset.pop", pop, 4'b0000);
    @(negedge clk);
    rst = 1'b1;

    // Single word from queue 2
    load(2, 8'hA5);
    step("single", 1, 1, 2'd2, 1);
    chk("single.data_a5", data_out, 8'hA5);
    step("single_idle", 1, 0, 2'd0, 1);

    // Backpressure: two pops then stall, drain in order, resume at occ=1
    load(3, 8'h31); load(3, 8'h32); load(3, 8'h33); load(3, 8'h34);
    step("bp1", 1, 1, 2'd3, 0);
    step("bp2", 1, 1, 2'd3, 0);
    step("bp3", 1, 1, 2'd3, 0);
    step("bp4", 1, 1, 2'd3, 0);
    step("bp5", 1, 1, 2'd3, 1);
    step("bp6", 1, 1, 2'd3, 1);
    step("bp7", 1, 1, 2'd3, 1);
    step("bp8", 1, 0, 2'd3, 1);
    step("bp9", 1, 0, 2'd3, 1);

    // Streaming 0,0,0,1,1,3
    load(0, 8'h10); load(0, 8'h11); load(0, 8'h12);
    load(1, 8'h13); load(1, 8'h14); load(3, 8'h15);
    step("st0", 1, 1, 2'd0, 1);
    step("st1", 1, 1, 2'd0, 1);
    step("st2", 1, 1, 2'd0, 1);
    step("st3", 1, 1, 2'd1, 1);
    step("st4", 1, 1, 2'd1, 1);
    step("st5", 1, 1, 2'd3, 1);
    step("st6", 1, 0, 2'd0, 1);

    // Underflow: queue 1 empty, others not
    load(0, 8'h40); load(2, 8'h42); load(3, 8'h43);
    step("uf0", 1, 1, 2'd1, 1);
    chk("uf0.set", underflow_err, 1'b1);
    step("uf1", 1, 0, 2'd1, 1);
    step("uf2", 1, 0, 2'd1, 1);

    // Enable low: no pop, output still drains
    step("en0", 1, 1, 2'd2, 0);
    step("en1", 0, 1, 2'd3, 1);
    step("en2", 0, 1, 2'd0, 1);

    // Asynchronous reset mid-cycle with the buffer full
    load(1, 8'h51); load(1, 8'h52); load(1, 8'h53);
    step("rs0", 1, 1, 2'd1, 0);
    step("rs1", 1, 1, 2'd1, 0);
    chk("rs1.full_valid", valid_out, 1'b1);
    enb = 1; selector_enb = 1; selector = 2'd0; ready_in = 0;
    drive_fifo();
    #2 rst = 1'b0;
    #1;
    oq.delete(); pops = 0; uf = 1'b0;
    check_outputs("rs_async");
    chk("rs_async.pop", pop, 4'b0000);
    chk("rs_async.adv", arb_advance, 1'b0);
    @(negedge clk);
    chk("rs_hold.pop", pop, 4'b0000);
    rst = 1'b1;
    step("rs_first", 1, 1, 2'd1, 1);
    chk("rs_first.data", data_out, 8'h53);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int q;
      q = $urandom_range(0, 3);
      if ($urandom_range(0, 2) != 0 && (fwr[q] - frd[q]) < 200) load(q, 8'($urandom));
      step("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    end
    for (int n = 0; n < 3; n++) step("tail", 1, 0, 2'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
